// File: rtl/clip_controller_if.sv
// Button, sample-tick, display and sample-memory signals of the clip controller.
// The master modport is the panel/memory side; the slave modport is the controller itself.
interface clip_controller_if #(
    parameter int OFF_W = 14
) ();
    logic               btn_record_i;
    logic               btn_play_i;
    logic               btn_next_i;
    logic               btn_prev_i;
    logic               sample_tick_i;
    logic [3:0]         sel_clip_o;
    logic [3:0]         play_clip_o;
    logic [3:0]         record_clip_o;
    logic               play_en_o;
    logic               record_en_o;
    logic [4+OFF_W-1:0] mem_addr_o;
    logic               mem_we_o;

    modport master (
        output btn_record_i, btn_play_i, btn_next_i, btn_prev_i, sample_tick_i,
        input  sel_clip_o, play_clip_o, record_clip_o, play_en_o, record_en_o,
        input  mem_addr_o, mem_we_o
    );

    modport slave (
        input  btn_record_i, btn_play_i, btn_next_i, btn_prev_i, sample_tick_i,
        output sel_clip_o, play_clip_o, record_clip_o, play_en_o, record_en_o,
        output mem_addr_o, mem_we_o
    );
endinterface

// File: rtl/clip_controller.sv
// Button debounce plus record/play FSM over a bank of clips with per-clip lengths.
// Define CLIP_CTRL_DEBOUNCE_EN to insert the per-button stability counters.
module clip_controller #(
    parameter int NUM_CLIPS       = 5,
    parameter int OFF_W           = 14,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock_i,
    input  logic             reset_i,
    clip_controller_if.slave bus
);
    localparam int LEN_W = OFF_W + 1;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

    // Button order in the vectors below: 0 record, 1 play, 2 next, 3 prev.
    logic [3:0] btn_raw;
    logic [3:0] press_reg;

    assign btn_raw = {bus.btn_prev_i, bus.btn_next_i, bus.btn_play_i, bus.btn_record_i};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic level;
            logic level_d_reg;

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

`ifdef CLIP_CTRL_DEBOUNCE_EN
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;

            // Any sample equal to the accepted level restarts the stability count.
            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_reg   <= '0;
                    level_reg <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign level = level_reg;
`else
            assign level = sync2_reg;
`endif

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    level_d_reg   <= 1'b0;
                    press_reg[gi] <= 1'b0;
                end else begin
                    level_d_reg   <= level;
                    press_reg[gi] <= level & ~level_d_reg;
                end
            end
        end
    endgenerate

    state_t           state_reg;
    logic [3:0]       sel_reg;
    logic [OFF_W-1:0] offset_reg;
    logic [LEN_W-1:0] len_reg [NUM_CLIPS];
    logic [3:0]       play_clip_reg;
    logic [3:0]       record_clip_reg;
    logic             play_en_reg;
    logic             record_en_reg;

    logic [LEN_W-1:0] len_sel;
    logic [LEN_W-1:0] offset_ext;
    logic [3:0]       sel_inc;
    logic [3:0]       sel_dec;
    logic             tick;

    assign tick       = bus.sample_tick_i;
    assign offset_ext = {1'b0, offset_reg};
    assign sel_inc    = (sel_reg == 4'(NUM_CLIPS - 1)) ? 4'd0 : sel_reg + 4'd1;
    assign sel_dec    = (sel_reg == 4'd0) ? 4'(NUM_CLIPS - 1) : sel_reg - 4'd1;

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (sel_reg == 4'(i)) len_sel = len_reg[i];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg       <= IDLE;
            sel_reg         <= 4'd0;
            offset_reg      <= '0;
            play_clip_reg   <= 4'hF;
            record_clip_reg <= 4'hF;
            play_en_reg     <= 1'b0;
            record_en_reg   <= 1'b0;
            for (int i = 0; i < NUM_CLIPS; i++) len_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (press_reg[0]) begin
                        state_reg       <= RECORD;
                        offset_reg      <= '0;
                        record_en_reg   <= 1'b1;
                        record_clip_reg <= sel_reg;
                        for (int i = 0; i < NUM_CLIPS; i++)
                            if (sel_reg == 4'(i)) len_reg[i] <= '0;
                    end else if (press_reg[1]) begin
                        if (len_sel != '0) begin
                            state_reg     <= PLAY;
                            offset_reg    <= '0;
                            play_en_reg   <= 1'b1;
                            play_clip_reg <= sel_reg;
                        end
                    end else if (press_reg[2]) begin
                        sel_reg <= sel_inc;
                    end else if (press_reg[3]) begin
                        sel_reg <= sel_dec;
                    end
                end
                RECORD: begin
                    // The tick's write is committed before any exit takes effect.
                    if (tick) begin
                        offset_reg <= offset_reg + OFF_W'(1);
                        for (int i = 0; i < NUM_CLIPS; i++)
                            if (sel_reg == 4'(i)) len_reg[i] <= offset_ext + LEN_W'(1);
                    end
                    if ((tick && offset_reg == {OFF_W{1'b1}}) || press_reg[0]) begin
                        state_reg       <= IDLE;
                        offset_reg      <= '0;
                        record_en_reg   <= 1'b0;
                        record_clip_reg <= 4'hF;
                    end
                end
                PLAY: begin
                    if (tick) offset_reg <= offset_reg + OFF_W'(1);
                    if ((tick && offset_ext == len_sel - LEN_W'(1)) || press_reg[1]) begin
                        state_reg     <= IDLE;
                        offset_reg    <= '0;
                        play_en_reg   <= 1'b0;
                        play_clip_reg <= 4'hF;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.sel_clip_o    = sel_reg;
    assign bus.play_clip_o   = play_clip_reg;
    assign bus.record_clip_o = record_clip_reg;
    assign bus.play_en_o     = play_en_reg;
    assign bus.record_en_o   = record_en_reg;
    assign bus.mem_addr_o    = {sel_reg, offset_reg};
    assign bus.mem_we_o      = record_en_reg & tick;
endmodule

// File: doc/clip_controller.md
# clip_controller

User-control stage directly upstream of the seven-segment clip display. It debounces the four front-panel buttons and runs the record/play state machine over a bank of audio clips. It tracks each clip's recorded length and generates sample-memory addresses and write strobes. It drives the 4-bit play and record clip numbers that the display shows, with 4'hF meaning "blank digit".

## Interface
Parameters:
- NUM_CLIPS, 5, number of clip slots (1..10); clip indices 0..NUM_CLIPS-1
- OFF_W, 14, width of per-clip sample offset; max clip length 2**OFF_W samples
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  reset, asynchronous, active-low
- btn_record_i / btn_play_i / btn_next_i / btn_prev_i  in  1 each  raw asynchronous buttons, active-high
- sample_tick_i  in  1  one-cycle pulse per audio sample period
- sel_clip_o  out  4  currently selected clip
- play_clip_o  out  4  selected clip while playing, else 4'hF
- record_clip_o  out  4  selected clip while recording, else 4'hF
- play_en_o / record_en_o  out  1 each  high while in PLAY / RECORD
- mem_addr_o  out  4+OFF_W  {sel_clip_o, offset}
- mem_we_o  out  1  sample write strobe

## Operation
- Each button path: 2-flop synchronizer, then the debounce filter (see Configuration), then a rising-edge detector. A press is a 1-cycle internal pulse.
- States: IDLE, RECORD, PLAY.
- IDLE:
  - Press priority when simultaneous: record > play > next > prev. Only the highest press acts; the others are dropped.
  - record: go to RECORD; offset=0; len[sel]=0.
  - play: if len[sel]!=0, go to PLAY with offset=0; if len[sel]==0, stay in IDLE.
  - next/prev: sel = sel±1 with wrap (NUM_CLIPS-1 -> 0, 0 -> NUM_CLIPS-1).
- RECORD:
  - On each sample_tick_i: mem_we_o=1 that cycle at the current offset; the next cycle offset++ and len[sel]=offset+1.
  - A record press returns to IDLE; len keeps the samples written so far.
  - A tick with offset==2**OFF_W-1 writes the last sample, sets len to 2**OFF_W, and returns to IDLE.
  - play, next and prev are ignored.
- PLAY:
  - On each tick: offset++.
  - A tick with offset==len[sel]-1 returns to IDLE; offset resets to 0.
  - A play press returns to IDLE.
  - record, next and prev are ignored.
- len[] is NUM_CLIPS registers of OFF_W+1 bits. A clip keeps its length until it is re-recorded or reset.
- A press and sample_tick_i in the same cycle: the tick is processed first (write or advance), then the state change takes effect.

## Timing
- Reset (asynchronous, reset_i low):
  - state=IDLE, sel_clip_o=0, offset=0, all len=0.
  - play_clip_o=record_clip_o=4'hF; play_en_o=record_en_o=0; mem_we_o=0; mem_addr_o=0.
  - Debounce and synchronizer state clear to 0.
- Reset asserted mid-RECORD discards the in-progress clip; its len becomes 0.
- Button to press pulse: 2 synchronizer cycles plus debounce latency (DEBOUNCE_CYCLES when enabled, 0 when disabled) plus 1 edge-detect cycle.
- Press pulse to state, enables, clip outputs and sel_clip_o: 1 cycle. All of these are registers.
- mem_we_o = record_en_o & sample_tick_i, combinational in the tick cycle. mem_addr_o is registered and stable during the tick cycle.

## Configuration
- CLIP_CTRL_DEBOUNCE_EN defined:
  - Each synchronized button has a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new value.
  - Any bounce resets the counter.
- CLIP_CTRL_DEBOUNCE_EN undefined:
  - No counters. The synchronized level feeds the edge detector directly; DEBOUNCE_CYCLES is unused.
  - Intended for simulation and pre-debounced inputs.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4, NUM_CLIPS=5, OFF_W=3.)
- Reset with buttons idle -> sel_clip_o=0, play_clip_o=record_clip_o=4'hF, both enables 0, mem_we_o=0.
- Pulse next 6 times, then prev 2 times -> sel_clip_o steps 1,2,3,4,0,1, then 0,4.
- Record on clip 2, issue 3 ticks, then press record -> exactly 3 mem_we_o pulses at offsets 0,1,2, record_clip_o=2 while recording, len[2]=3, back to IDLE.
- Play clip 2 -> play_clip_o=2 and play_en_o=1; PLAY ends automatically after the 3rd tick with play_clip_o=4'hF. Play on empty clip 0 -> stays in IDLE.
- Record with 8 ticks -> 8 writes at offsets 0..7, automatic return to IDLE, len=8. A 9th tick gives no write.
- Button bounce of 3 cycles high then 1 low (debounce enabled) -> no press. Simultaneous record+play in IDLE -> RECORD entered. Reset mid-RECORD -> len=0 and outputs at reset values.
